// File: rtl/spi_snn_pkg.sv
// Shared SPI framing definitions for the SNN link (master and slave sides).
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package spi_snn_pkg;

   // Instruction opcodes carried in the first frame phase
   localparam logic [6:0] OP_WRITE = 7'h01;
   localparam logic [6:0] OP_READ  = 7'h02;

   // Phase lengths in bits: instruction, address, data (lead/turnaround bit + word)
   localparam int SPI_INSTR_BITS = 7;
   localparam int SPI_ADDR_BITS  = 16;
   localparam int SPI_DATA_BITS  = 33;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      HOLD,
      GAP
   } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock divider: sclk idles low, each half-period is CLK_DIV clk cycles.
// Latency: first rising edge CLK_DIV cycles after en goes high.
// Backpressure: none; dropping en returns sclk low and clears the divider at once.
module spi_sclk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic sclk,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int DIV_WIDTH = $clog2(CLK_DIV + 1);
   localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(CLK_DIV - 1);
   localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);

   logic [DIV_WIDTH-1:0] div_cnt;
   logic                 phase_end;

   // Strobes are valid in the cycle whose closing edge toggles sclk
   assign phase_end  = en && (div_cnt == DIV_LAST);
   assign rise_pulse = phase_end && !sclk;
   assign fall_pulse = phase_end && sclk;

   // Half-period counter; sclk toggles each time a phase completes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
      end else if (!en) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
      end else if (phase_end) begin
         div_cnt <= '0;
         sclk    <= ~sclk;
      end else begin
         div_cnt <= div_cnt + DIV_ONE;
      end
   end

endmodule

// File: rtl/spi_master_snn.sv
// SPI mode-0 master: one 56-bit instr/addr/data frame per accepted command, read word returned on rsp.
// Latency: rsp_valid_o 1+113*CLK_DIV cycles after the accept edge, ready again at 1+114*CLK_DIV.
// Backpressure: cmd_ready_o low from accept until the inter-frame gap ends; cmd_valid_i while busy is ignored.
// Optional feature: define SPI_MASTER_SNN_TXN_CNT_EN to add the saturating txn_cnt_o completion counter.
module spi_master_snn
   import spi_snn_pkg::*;
#(
   parameter int INSTR_TRANS_WIDTH = SPI_INSTR_BITS,
   parameter int ADDR_TRANS_WIDTH  = SPI_ADDR_BITS,
   parameter int DATA_TRANS_WIDTH  = SPI_DATA_BITS,
   parameter int ADDR_WIDTH        = 9,
   parameter int DATA_WIDTH        = 32,
   parameter int CLK_DIV           = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_we_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
   output logic                  rsp_valid_o,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  busy_o,
   output logic                  sclk_o,
   output logic                  cs_n_o,
   output logic                  mosi_o,
   input  logic                  miso_i
`ifdef SPI_MASTER_SNN_TXN_CNT_EN
   ,
   output logic [15:0]           txn_cnt_o
`endif
);

   localparam int FRAME_WIDTH = INSTR_TRANS_WIDTH + ADDR_TRANS_WIDTH + DATA_TRANS_WIDTH;
   localparam int CNT_WIDTH   = $clog2(FRAME_WIDTH);
   // The bit counter doubles as the HOLD/GAP phase timer, so CLK_DIV-1 must fit in it
   localparam logic [CNT_WIDTH-1:0] LAST_BIT   = CNT_WIDTH'(FRAME_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] PHASE_LAST = CNT_WIDTH'(CLK_DIV - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

   state_t                 state;
   logic [CNT_WIDTH-1:0]   bit_cnt;
   logic [FRAME_WIDTH-1:0] tx_sr;
   logic [FRAME_WIDTH-1:0] frame;
   logic [DATA_WIDTH-1:0]  rx_sr;
   logic                   txn_we;
   logic                   accept;
   logic                   sclk_en;
   logic                   rise_pulse;
   logic                   fall_pulse;

   assign accept  = cmd_valid_i && cmd_ready_o;
   assign sclk_en = (state == SHIFT);

   // Reads send zeros through the whole data phase; writes lead with a single 0 bit
   assign frame = {INSTR_TRANS_WIDTH'(cmd_we_i ? OP_WRITE : OP_READ),
                   ADDR_TRANS_WIDTH'(cmd_addr_i),
                   (cmd_we_i ? DATA_TRANS_WIDTH'(cmd_wdata_i) : DATA_TRANS_WIDTH'(0))};

   spi_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk        (clk_i),
      .rst        (rst_i),
      .en         (sclk_en),
      .sclk       (sclk_o),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
   );

   // Frame sequencer: MOSI advances on each SCLK fall, then HOLD and GAP keep the slave timing clean
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         tx_sr       <= '0;
         txn_we      <= 1'b0;
         cmd_ready_o <= 1'b1;
         busy_o      <= 1'b0;
         cs_n_o      <= 1'b1;
         mosi_o      <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= '0;
      end else begin
         rsp_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state       <= SHIFT;
                  txn_we      <= cmd_we_i;
                  mosi_o      <= frame[FRAME_WIDTH-1];
                  tx_sr       <= frame << 1;
                  bit_cnt     <= LAST_BIT;
                  cmd_ready_o <= 1'b0;
                  busy_o      <= 1'b1;
                  cs_n_o      <= 1'b0;
               end
            end
            SHIFT: begin
               if (fall_pulse) begin
                  if (bit_cnt == '0) begin
                     state   <= HOLD;
                     mosi_o  <= 1'b0;
                     bit_cnt <= PHASE_LAST;
                  end else begin
                     bit_cnt <= bit_cnt - CNT_ONE;
                     mosi_o  <= tx_sr[FRAME_WIDTH-1];
                     tx_sr   <= tx_sr << 1;
                  end
               end
            end
            HOLD: begin
               if (bit_cnt == '0) begin
                  state       <= GAP;
                  cs_n_o      <= 1'b1;
                  rsp_valid_o <= 1'b1;
                  bit_cnt     <= PHASE_LAST;
                  if (!txn_we) begin
                     rsp_rdata_o <= rx_sr;
                  end
               end else begin
                  bit_cnt <= bit_cnt - CNT_ONE;
               end
            end
            GAP: begin
               if (bit_cnt == '0) begin
                  state       <= IDLE;
                  cmd_ready_o <= 1'b1;
                  busy_o      <= 1'b0;
               end else begin
                  bit_cnt <= bit_cnt - CNT_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // MISO capture on each SCLK rise; after the frame only the last DATA_WIDTH bits remain
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_sr <= '0;
      end else if (rise_pulse) begin
         rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso_i};
      end
   end

`ifdef SPI_MASTER_SNN_TXN_CNT_EN
   // Completed-transaction counter, saturating, cleared only by reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         txn_cnt_o <= '0;
      end else if (rsp_valid_o && (txn_cnt_o != 16'hFFFF)) begin
         txn_cnt_o <= txn_cnt_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_spi_master_snn.sv
// Bench for spi_master_snn: CLK_DIV=2 instance with a scoreboard plus a CLK_DIV=1 instance.
// Latency: expected rsp cycle is pushed at accept and compared when rsp_valid_o pulses.
// Backpressure: commands wait (bounded) for cmd_ready_o before being counted as accepted.
module tb_spi_master_snn;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- CLK_DIV=2 instance ----------------
   logic        c_valid, c_we;
   logic [8:0]  c_addr;
   logic [31:0] c_wdata;
   logic        cmd_ready, rsp_valid, busy, sclk, cs_n, mosi, miso;
   logic [31:0] rsp_rdata;
   // ---------------- CLK_DIV=1 instance ----------------
   logic        d_valid, d_we;
   logic [8:0]  d_addr;
   logic [31:0] d_wdata;
   logic        d_ready, d_rsp_valid, d_busy, d_sclk, d_cs_n, d_mosi, d_miso;
   logic [31:0] d_rdata;
`ifdef SPI_MASTER_SNN_TXN_CNT_EN
   logic [15:0] txn0, txn1;
`endif

   spi_master_snn #(.CLK_DIV(2)) u_dut (
      .clk_i(clk), .rst_i(rst), .cmd_valid_i(c_valid), .cmd_ready_o(cmd_ready),
      .cmd_we_i(c_we), .cmd_addr_i(c_addr), .cmd_wdata_i(c_wdata),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .busy_o(busy),
      .sclk_o(sclk), .cs_n_o(cs_n), .mosi_o(mosi), .miso_i(miso)
`ifdef SPI_MASTER_SNN_TXN_CNT_EN
      , .txn_cnt_o(txn0)
`endif
   );

   spi_master_snn #(.CLK_DIV(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .cmd_valid_i(d_valid), .cmd_ready_o(d_ready),
      .cmd_we_i(d_we), .cmd_addr_i(d_addr), .cmd_wdata_i(d_wdata),
      .rsp_valid_o(d_rsp_valid), .rsp_rdata_o(d_rdata), .busy_o(d_busy),
      .sclk_o(d_sclk), .cs_n_o(d_cs_n), .mosi_o(d_mosi), .miso_i(d_miso)
`ifdef SPI_MASTER_SNN_TXN_CNT_EN
      , .txn_cnt_o(txn1)
`endif
   );

   // Slave model, instance 0: MISO changes after each SCLK fall; MOSI captured on each rise
   logic [31:0] miso_word = 32'd0;
   logic [55:0] slv_frame, cap = 56'd0;
   int fall_cnt = 0, fall_base = 0, rise_cnt = 0, rise_base = 0, frames = 0, idx;
   always @(negedge sclk) fall_cnt++;
   always @(posedge sclk) begin rise_cnt++; cap = {cap[54:0], mosi}; end
   always @(negedge cs_n) begin fall_base = fall_cnt; rise_base = rise_cnt; frames++; end
   assign slv_frame = {23'd0, 1'b1, miso_word};
   always_comb begin
      idx  = fall_cnt - fall_base;
      miso = (idx >= 0 && idx < 56) ? slv_frame[6'(55 - idx)] : 1'b0;
   end

   // Slave model, instance 1
   logic [31:0] miso_word1 = 32'd0;
   logic [55:0] slv_frame1;
   int fall_cnt1 = 0, fall_base1 = 0, idx1;
   always @(negedge d_sclk) fall_cnt1++;
   always @(negedge d_cs_n) fall_base1 = fall_cnt1;
   assign slv_frame1 = {23'd0, 1'b1, miso_word1};
   always_comb begin
      idx1   = fall_cnt1 - fall_base1;
      d_miso = (idx1 >= 0 && idx1 < 56) ? slv_frame1[6'(55 - idx1)] : 1'b0;
   end

   // Length of the most recent run of cs_n high cycles that ended with a new frame
   int hi_run = 0, last_hi_run = 0;
   always @(negedge clk) begin
      if (cs_n) hi_run++;
      else begin
         if (hi_run != 0) last_hi_run = hi_run;
         hi_run = 0;
      end
   end

   typedef struct {
      int unsigned cyc;
      logic [31:0] rdata;
      logic [55:0] frame;
   } exp_t;
   exp_t sb[$];

   // Scoreboard: every completion must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid === 1'b1) begin
         chk("rsp_expected", sb.size() > 0, 1'b1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_cycle", cyc, e.cyc);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("mosi_frame", cap, e.frame);
            chk("sclk_rises", rise_cnt - rise_base, 56);
         end
      end
   end

   function automatic logic [55:0] exp_frame(input logic we, input logic [8:0] addr, input logic [31:0] wd);
      logic [6:0] op;
      op = we ? 7'h01 : 7'h02;
      return {op, 7'd0, addr, 1'b0, (we ? wd : 32'd0)};
   endfunction

   task automatic issue(input logic we, input logic [8:0] addr, input logic [31:0] wd,
                        input logic [31:0] mw, input logic [31:0] exp_rd,
                        input bit push, input bit drop, output int unsigned e0);
      bit seen = 0;
      @(negedge clk);
      miso_word = mw; c_we = we; c_addr = addr; c_wdata = wd; c_valid = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if (cmd_ready) begin seen = 1; break; end
         @(negedge clk);
      end
      chk("accept_seen", seen, 1'b1);
      e0 = cyc;
      if (push) sb.push_back('{cyc: cyc + 227, rdata: exp_rd, frame: exp_frame(we, addr, wd)});
      if (drop) begin @(negedge clk); c_valid = 1'b0; end
   endtask

   task automatic wait_done(input string name);
      bit ok = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && cmd_ready && !busy) begin ok = 1; break; end
      end
      chk(name, ok, 1'b1);
   endtask

   task automatic issue1(input logic we, input logic [8:0] addr, input logic [31:0] wd,
                         input logic [31:0] mw, output int unsigned lat, output logic [31:0] rd);
      bit seen = 0, done = 0;
      int unsigned e0;
      @(negedge clk);
      miso_word1 = mw; d_we = we; d_addr = addr; d_wdata = wd; d_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (d_ready) begin seen = 1; break; end
         @(negedge clk);
      end
      chk("d1_accept_seen", seen, 1'b1);
      e0 = cyc;
      @(negedge clk);
      d_valid = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (d_rsp_valid) begin done = 1; break; end
         @(negedge clk);
      end
      chk("d1_rsp_seen", done, 1'b1);
      lat = cyc - e0;
      rd  = d_rdata;
      repeat (4) @(negedge clk);
   endtask

   typedef struct {
      logic        we;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic [31:0] miso_word;
      logic [31:0] exp_rdata;
   } vec_t;
   vec_t vecs[5];

   initial begin
      #600000;
      $display("FAIL watchdog: time limit reached, checks so far %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned e0, e1, lat;
      logic [31:0] rd;
      int f0;

      vecs[0] = '{1'b1, 9'h1A5, 32'hDEADBEEF, 32'h00000000, 32'h00000000};
      vecs[1] = '{1'b0, 9'h003, 32'h00000000, 32'h12345678, 32'h12345678};
      vecs[2] = '{1'b1, 9'h0FF, 32'h00000001, 32'hFFFFFFFF, 32'h12345678};
      vecs[3] = '{1'b0, 9'h1FF, 32'hFFFFFFFF, 32'hA5C30F96, 32'hA5C30F96};
      vecs[4] = '{1'b0, 9'h100, 32'h00000000, 32'h0F1E2D3C, 32'h0F1E2D3C};

      rst = 1'b1;
      c_valid = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
      d_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_cmd_ready", cmd_ready, 1'b1);
      chk("reset_rsp_valid", rsp_valid, 1'b0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_sclk", sclk, 1'b0);
      chk("reset_cs_n", cs_n, 1'b1);
      chk("reset_mosi", mosi, 1'b0);
`ifdef SPI_MASTER_SNN_TXN_CNT_EN
      chk("reset_txn_cnt", txn1, 16'd0);
`endif

      // Table of single transactions, each run to completion
      for (int i = 0; i < 5; i++) begin
         issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].miso_word,
               vecs[i].exp_rdata, 1'b1, 1'b1, e0);
         wait_done("vec_done");
      end

      // Back-to-back write then read with cmd_valid held high
      issue(1'b1, 9'h0AA, 32'h13579BDF, 32'h0, 32'h0F1E2D3C, 1'b1, 1'b0, e0);
      issue(1'b0, 9'h055, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 1'b1, e1);
      chk("b2b_accept_spacing", e1 - e0, 229);
      wait_done("b2b_done");
      // Two GAP cycles plus the cycle in which the next command is accepted
      chk("b2b_cs_n_high_cycles", last_hi_run, 3);

      // cmd_valid pulsed mid-frame must be ignored
      f0 = frames;
      issue(1'b1, 9'h010, 32'h0F0F0F0F, 32'h0, 32'hCAFEF00D, 1'b1, 1'b1, e0);
      repeat (60) @(negedge clk);
      c_valid = 1'b1; c_addr = 9'h077;
      chk("ready_low_while_busy", cmd_ready, 1'b0);
      @(negedge clk);
      chk("ready_still_low", cmd_ready, 1'b0);
      c_valid = 1'b0;
      wait_done("pulse_done");
      repeat (20) @(negedge clk);
      chk("pulse_frame_count", frames - f0, 1);

      // CLK_DIV=1 instance: latency and optional completion counter
      issue1(1'b0, 9'h042, 32'h0, 32'h87654321, lat, rd);
      chk("d1_read_latency", lat, 114);
      chk("d1_read_rdata", rd, 32'h87654321);
`ifdef SPI_MASTER_SNN_TXN_CNT_EN
      chk("d1_txn_cnt_1", txn1, 16'd1);
`endif
      issue1(1'b1, 9'h043, 32'h24681357, 32'hFFFF0000, lat, rd);
      chk("d1_write_latency", lat, 114);
      chk("d1_write_rdata_kept", rd, 32'h87654321);
`ifdef SPI_MASTER_SNN_TXN_CNT_EN
      chk("d1_txn_cnt_2", txn1, 16'd2);
`endif

      // Reset asserted after 30 bits of a read frame
      f0 = frames;
      issue(1'b0, 9'h0AB, 32'h0, 32'h55AA55AA, 32'h0, 1'b0, 1'b1, e0);
      begin
         bit hit = 0;
         for (int i = 0; i < 200; i++) begin
            if (rise_cnt - rise_base >= 30) begin hit = 1; break; end
            @(negedge clk);
         end
         chk("reached_bit30", hit, 1'b1);
      end
      rst = 1'b1;
      #1;
      chk("rst_cs_n_immediate", cs_n, 1'b1);
      chk("rst_sclk_immediate", sclk, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (250) @(negedge clk);
      chk("rst_ready_after", cmd_ready, 1'b1);
      chk("rst_rdata_cleared", rsp_rdata, 32'd0);
      chk("rst_no_new_frame", frames - f0, 1);
      issue(1'b0, 9'h0FF, 32'h0, 32'h0BADCAFE, 32'h0BADCAFE, 1'b1, 1'b1, e0);
      wait_done("post_reset_done");

      chk("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
